// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source FIFOs feeding one scoreboard writeback port.
// Define WB_ARBITER_RR_EN for round-robin; default is fixed lowest-index priority.
module wb_arbiter #(
    parameter int NR_WB_PORTS   = 4,
    parameter int DEPTH         = 2,
    parameter int TRANS_ID_BITS = 3,
    parameter int XLEN          = 64,
    parameter int EXW           = 129
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
    input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]   wb_trans_id_i,
    input  logic [NR_WB_PORTS*XLEN-1:0]            wb_result_i,
    input  logic [NR_WB_PORTS*EXW-1:0]             wb_ex_i,
    output logic [NR_WB_PORTS-1:0]                 port_full_o,
    output logic                                   sb_valid_o,
    input  logic                                   sb_ready_i,
    output logic [TRANS_ID_BITS-1:0]               sb_trans_id_o,
    output logic [XLEN-1:0]                        sb_result_o,
    output logic [EXW-1:0]                         sb_ex_o,
    output logic                                   overflow_o
);

    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int IW  = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;
    localparam int CIW = IW + 1;
    localparam int EW  = TRANS_ID_BITS + XLEN + EXW;

    logic [EW-1:0] mem_q [NR_WB_PORTS][DEPTH];
    logic [EW-1:0] mem_d [NR_WB_PORTS][DEPTH];
    logic [PW-1:0] wr_ptr_q [NR_WB_PORTS];
    logic [PW-1:0] wr_ptr_d [NR_WB_PORTS];
    logic [PW-1:0] rd_ptr_q [NR_WB_PORTS];
    logic [PW-1:0] rd_ptr_d [NR_WB_PORTS];
    logic [CW-1:0] cnt_q [NR_WB_PORTS];
    logic [CW-1:0] cnt_d [NR_WB_PORTS];

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic          lock_q, lock_d;
    logic          overflow_q, overflow_d;

    logic [NR_WB_PORTS-1:0] nonempty;
    logic [IW-1:0]          arb_idx;
    logic [IW-1:0]          sel;
    logic [CIW-1:0]         cand;
    logic                   found;
    logic                   pop;
    logic [EW-1:0]          head;

    always_comb begin
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            nonempty[p]    = (cnt_q[p] != '0);
            port_full_o[p] = (cnt_q[p] >= CW'(DEPTH - 1));
        end
    end

    // Scan starts at the round-robin pointer; it stays at 0 in fixed mode.
    always_comb begin
        arb_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NR_WB_PORTS; i++) begin
            cand = {1'b0, rr_ptr_q} + CIW'(i);
            if (cand >= CIW'(NR_WB_PORTS))
                cand = cand - CIW'(NR_WB_PORTS);
            if (!found && nonempty[cand[IW-1:0]]) begin
                arb_idx = cand[IW-1:0];
                found   = 1'b1;
            end
        end
    end

    assign sel        = lock_q ? gnt_q : arb_idx;
    assign sb_valid_o = |nonempty;
    assign pop        = sb_valid_o & sb_ready_i;
    assign head       = mem_q[sel][rd_ptr_q[sel]];

    assign sb_trans_id_o = sb_valid_o ? head[EW-1 -: TRANS_ID_BITS] : '0;
    assign sb_result_o   = sb_valid_o ? head[EXW +: XLEN] : '0;
    assign sb_ex_o       = sb_valid_o ? head[EXW-1:0] : '0;
    assign overflow_o    = overflow_q;

    always_comb begin
        logic          pop_p;
        logic          full;
        logic          acc;
        logic [EW-1:0] entry;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        pop_p      = 1'b0;
        full       = 1'b0;
        acc        = 1'b0;
        entry      = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            pop_p = pop && (sel == IW'(p));
            full  = (cnt_q[p] == CW'(DEPTH));
            acc   = wb_valid_i[p] && (!full || pop_p);
            entry = {wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS],
                     wb_result_i[p*XLEN +: XLEN],
                     wb_ex_i[p*EXW +: EXW]};
            if (wb_valid_i[p] && full && !pop_p)
                overflow_d = 1'b1;
            if (flush_i) begin
                wr_ptr_d[p] = '0;
                rd_ptr_d[p] = '0;
                cnt_d[p]    = '0;
            end else begin
                if (acc) begin
                    mem_d[p][wr_ptr_q[p]] = entry;
                    wr_ptr_d[p] = wr_ptr_q[p] + PW'(1);
                end
                if (pop_p)
                    rd_ptr_d[p] = rd_ptr_q[p] + PW'(1);
                if (acc && !pop_p)
                    cnt_d[p] = cnt_q[p] + CW'(1);
                else if (!acc && pop_p)
                    cnt_d[p] = cnt_q[p] - CW'(1);
            end
        end
    end

    // A stalled grant is frozen so the scoreboard sees stable outputs.
    always_comb begin
        lock_d = sb_valid_o && !sb_ready_i && !flush_i;
        gnt_d  = sel;
`ifdef WB_ARBITER_RR_EN
        rr_ptr_d = rr_ptr_q;
        if (pop)
            rr_ptr_d = (sel == IW'(NR_WB_PORTS - 1)) ? '0 : sel + IW'(1);
`else
        rr_ptr_d = '0;
`endif
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
            end
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            lock_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            lock_q     <= lock_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writebacks queued at drive time.
module tb_wb_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   wb_valid;
    logic [11:0]  wb_trans_id;
    logic [255:0] wb_result;
    logic [515:0] wb_ex;
    logic [3:0]   port_full;
    logic         sb_valid;
    logic         sb_ready;
    logic [2:0]   sb_trans_id;
    logic [63:0]  sb_result;
    logic [128:0] sb_ex;
    logic         overflow;

    typedef struct packed {
        logic [2:0]   id;
        logic [63:0]  res;
        logic [128:0] ex;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .wb_valid_i    (wb_valid),
        .wb_trans_id_i (wb_trans_id),
        .wb_result_i   (wb_result),
        .wb_ex_i       (wb_ex),
        .port_full_o   (port_full),
        .sb_valid_o    (sb_valid),
        .sb_ready_i    (sb_ready),
        .sb_trans_id_o (sb_trans_id),
        .sb_result_o   (sb_result),
        .sb_ex_o       (sb_ex),
        .overflow_o    (overflow)
    );

    task automatic check(input string tag,
                         input logic [255:0] got,
                         input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_res(int p, int id);
        return 64'h1000_0000 + 64'(p) * 64'h100 + 64'(id);
    endfunction

    function automatic logic [128:0] mk_ex(int p, int id);
        return {64'hC0 + 64'(p), 64'hA000 + 64'(id), 1'(id)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(int p, int id, logic [63:0] res,
                            logic [128:0] ex);
        wb_valid[p] = 1'b1;
        wb_trans_id[p*3 +: 3] = 3'(id);
        wb_result[p*64 +: 64] = res;
        wb_ex[p*129 +: 129] = ex;
    endtask

    task automatic expect_wb(int id, logic [63:0] res, logic [128:0] ex);
        sb_q.push_back('{id: 3'(id), res: res, ex: ex});
    endtask

    task automatic pulse();
        tick();
        wb_valid = '0;
    endtask

    task automatic push_std(int p, int id, bit exp);
        set_port(p, id, mk_res(p, id), mk_ex(p, id));
        if (exp)
            expect_wb(id, mk_res(p, id), mk_ex(p, id));
        pulse();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && sb_valid && sb_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_wb", {253'd0, sb_trans_id}, 256'hEEE);
            end else begin
                mon_e = sb_q.pop_front();
                check("wb_id", {253'd0, sb_trans_id}, {253'd0, mon_e.id});
                check("wb_res", {192'd0, sb_result}, {192'd0, mon_e.res});
                check("wb_ex", {127'd0, sb_ex}, {127'd0, mon_e.ex});
            end
        end
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        wb_valid = '0;
        wb_trans_id = '0;
        wb_result = '0;
        wb_ex = '0;
        sb_ready = 1'b0;
        @(negedge clk);
        check("rst_valid", {255'd0, sb_valid}, 256'd0);
        check("rst_full", {252'd0, port_full}, 256'd0);
        check("rst_ovf", {255'd0, overflow}, 256'd0);
        check("rst_id", {253'd0, sb_trans_id}, 256'd0);
        check("rst_res", {192'd0, sb_result}, 256'd0);
        tick();
        rst = 1'b0;
        tick();

        // single push
        sb_ready = 1'b1;
        set_port(0, 3, 64'hDEAD, mk_ex(0, 2));
        expect_wb(3, 64'hDEAD, mk_ex(0, 2));
        check("single_pre", {255'd0, sb_valid}, 256'd0);
        pulse();
        check("single_valid", {255'd0, sb_valid}, 256'd1);
        tick();
        check("single_empty", {255'd0, sb_valid}, 256'd0);
        check("single_full", {252'd0, port_full}, 256'd0);

        // contention from reset
        do_reset();
        for (int p = 0; p < 4; p++) begin
            set_port(p, p, mk_res(p, p), mk_ex(p, p));
            expect_wb(p, mk_res(p, p), mk_ex(p, p));
        end
        pulse();
        for (int k = 0; k < 4; k++) begin
            check("cont_valid", {255'd0, sb_valid}, 256'd1);
            tick();
        end
        check("cont_done", {255'd0, sb_valid}, 256'd0);

        // policy: FLU and load both loaded
        sb_ready = 1'b0;
        set_port(0, 1, mk_res(0, 1), mk_ex(0, 1));
        set_port(1, 2, mk_res(1, 2), mk_ex(1, 2));
        pulse();
        set_port(0, 3, mk_res(0, 3), mk_ex(0, 3));
        set_port(1, 4, mk_res(1, 4), mk_ex(1, 4));
        pulse();
`ifdef WB_ARBITER_RR_EN
        expect_wb(1, mk_res(0, 1), mk_ex(0, 1));
        expect_wb(2, mk_res(1, 2), mk_ex(1, 2));
        expect_wb(3, mk_res(0, 3), mk_ex(0, 3));
        expect_wb(4, mk_res(1, 4), mk_ex(1, 4));
`else
        expect_wb(1, mk_res(0, 1), mk_ex(0, 1));
        expect_wb(3, mk_res(0, 3), mk_ex(0, 3));
        expect_wb(2, mk_res(1, 2), mk_ex(1, 2));
        expect_wb(4, mk_res(1, 4), mk_ex(1, 4));
`endif
        check("pol_full", {252'd0, port_full}, 256'h3);
        check("pol_ovf", {255'd0, overflow}, 256'd0);
        sb_ready = 1'b1;
        for (int k = 0; k < 4; k++)
            tick();
        check("pol_done", {255'd0, sb_valid}, 256'd0);

        // stall and overflow on load port
        sb_ready = 1'b0;
        push_std(1, 5, 1'b1);
        check("stall_full1", {252'd0, port_full}, 256'h2);
        check("stall_id1", {253'd0, sb_trans_id}, 256'd5);
        push_std(1, 6, 1'b1);
        check("stall_ovf0", {255'd0, overflow}, 256'd0);
        check("stall_id2", {253'd0, sb_trans_id}, 256'd5);
        push_std(1, 7, 1'b0);
        check("stall_ovf1", {255'd0, overflow}, 256'd1);
        check("stall_id3", {253'd0, sb_trans_id}, 256'd5);
        check("stall_res3", {192'd0, sb_result}, {192'd0, mk_res(1, 5)});
        sb_ready = 1'b1;
        tick();
        tick();
        check("stall_done", {255'd0, sb_valid}, 256'd0);

        // flush against a simultaneous push
        sb_ready = 1'b0;
        push_std(2, 1, 1'b0);
        push_std(2, 2, 1'b0);
        check("fl_pre", {255'd0, sb_valid}, 256'd1);
        flush = 1'b1;
        set_port(2, 4, mk_res(2, 4), mk_ex(2, 4));
        pulse();
        flush = 1'b0;
        check("fl_valid", {255'd0, sb_valid}, 256'd0);
        check("fl_full", {252'd0, port_full}, 256'd0);
        check("fl_ovf", {255'd0, overflow}, 256'd1);
        sb_ready = 1'b1;
        tick();
        check("fl_stay", {255'd0, sb_valid}, 256'd0);

        // async reset while stalled
        sb_ready = 1'b0;
        push_std(3, 6, 1'b0);
        push_std(3, 7, 1'b0);
        check("rs_pre", {255'd0, sb_valid}, 256'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rs_valid", {255'd0, sb_valid}, 256'd0);
        check("rs_id", {253'd0, sb_trans_id}, 256'd0);
        check("rs_ovf", {255'd0, overflow}, 256'd0);
        #3;
        rst = 1'b0;
        tick();
        sb_ready = 1'b1;
        tick();
        check("rs_empty", {255'd0, sb_valid}, 256'd0);
        check("rs_full", {252'd0, port_full}, 256'd0);

        check("sb_left", 256'(sb_q.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
